sysid_check_ctrl: RTL and testbench

SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

---
 rtl/sysid_check_ctrl.sv | 123 ++++++++++++
 tb/tb_sysid_check_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sysid_check_ctrl.sv
// Reads the system ID (address 0) and optionally the timestamp (address 1) from a sysid slave and
// compares them with expected values. Define SYSID_CHECK_TIMESTAMP_EN to include the timestamp read.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID   = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS   = 32'h0000_0000,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        mismatch,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

`ifdef SYSID_CHECK_TIMESTAMP_EN
  typedef enum logic [1:0] {SETTLE, RD_ID, RD_TS, DONE} state_t;
  logic [31:0] captured_ts_q;
  assign captured_ts = captured_ts_q;
`else
  typedef enum logic [1:0] {SETTLE, RD_ID, DONE} state_t;
  localparam logic [31:0] unused_expected_ts = EXPECTED_TS;
  assign captured_ts = '0;
`endif

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] READ_LAST   = 8'(READ_LATENCY);

  state_t     state;
  logic [7:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= SETTLE;
      cnt           <= '0;
      sysid_address <= 1'b0;
      busy          <= 1'b1;
      done          <= 1'b0;
      id_ok         <= 1'b0;
      ts_ok         <= 1'b0;
      mismatch      <= 1'b0;
      captured_id   <= '0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
      captured_ts_q <= '0;
`endif
    end else begin
      case (state)
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= RD_ID;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RD_ID: begin
          if (cnt == READ_LAST) begin
            cnt         <= '0;
            captured_id <= sysid_readdata;
`ifdef SYSID_CHECK_TIMESTAMP_EN
            state         <= RD_TS;
            sysid_address <= 1'b1;
`else
            // Without the timestamp read the verdict is formed straight from the sampled ID.
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            id_ok    <= (sysid_readdata == EXPECTED_ID);
            ts_ok    <= 1'b1;
            mismatch <= (sysid_readdata != EXPECTED_ID);
`endif
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
`ifdef SYSID_CHECK_TIMESTAMP_EN
        RD_TS: begin
          if (cnt == READ_LAST) begin
            cnt           <= '0;
            captured_ts_q <= sysid_readdata;
            sysid_address <= 1'b0;
            state         <= DONE;
            busy          <= 1'b0;
            done          <= 1'b1;
            id_ok         <= (captured_id == EXPECTED_ID);
            ts_ok         <= (sysid_readdata == EXPECTED_TS);
            mismatch      <= !((captured_id == EXPECTED_ID) && (sysid_readdata == EXPECTED_TS));
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
`endif
        DONE: begin
          if (start) begin
            state       <= SETTLE;
            cnt         <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            mismatch    <= 1'b0;
            captured_id <= '0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
            captured_ts_q <= '0;
`endif
          end
        end
        default: begin
          state <= SETTLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl: one instance with READ_LATENCY=1 and one with READ_LATENCY=3,
// each fed by a registered slave model with matching delay. Expectations follow SYSID_CHECK_TIMESTAMP_EN.
module tb_sysid_check_ctrl;
  localparam logic [31:0] EXP_ID = 32'h0000_ABCD;
  localparam logic [31:0] EXP_TS = 32'h5989_F5E8;
`ifdef SYSID_CHECK_TIMESTAMP_EN
  localparam int LAT = 8, LAT3 = 12, A1 = 2, A1_3 = 4;
  localparam logic [31:0] CTS_GOOD = EXP_TS;
  localparam logic TS_OK_BADTS = 1'b0;
`else
  localparam int LAT = 6, LAT3 = 8, A1 = 0, A1_3 = 0;
  localparam logic [31:0] CTS_GOOD = 32'h0;
  localparam logic TS_OK_BADTS = 1'b1;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] id_val = EXP_ID, ts_val = EXP_TS;
  logic addr, busy, done, id_ok, ts_ok, mm;
  logic [31:0] rdata, cid, cts;
  logic addr3, busy3, done3, id_ok3, ts_ok3, mm3;
  logic [31:0] rdata3, cid3, cts3;
  logic [31:0] pipe3 [3];
  int total = 0, bad = 0;
  int lat, lat3, a1, a13, both;

  always #5 clk = ~clk;

  sysid_check_ctrl #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .SETTLE_CYCLES(4), .READ_LATENCY(1)) dut (
    .clock(clk), .reset(rst), .start(start), .sysid_address(addr), .sysid_readdata(rdata),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .mismatch(mm),
    .captured_id(cid), .captured_ts(cts));

  sysid_check_ctrl #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .SETTLE_CYCLES(4), .READ_LATENCY(3)) dut3 (
    .clock(clk), .reset(rst), .start(start), .sysid_address(addr3), .sysid_readdata(rdata3),
    .busy(busy3), .done(done3), .id_ok(id_ok3), .ts_ok(ts_ok3), .mismatch(mm3),
    .captured_id(cid3), .captured_ts(cts3));

  always_ff @(posedge clk) begin
    rdata    <= addr ? ts_val : id_val;
    pipe3[0] <= addr3 ? ts_val : id_val;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rdata3 = pipe3[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts edges until both instances show done; start is pulsed so it is sampled at edge start_at.
  task automatic measure(input int start_at, output int l, output int l3, output int c1,
                         output int c13, output int ov);
    l = 0; l3 = 0; c1 = 0; c13 = 0; ov = 0;
    for (int i = 1; i <= 40 && (l == 0 || l3 == 0); i++) begin
      start = (i == start_at);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done && l == 0) l = i;
      if (done3 && l3 == 0) l3 = i;
      if (addr) c1++;
      if (addr3) c13++;
      if ((busy && done) || (busy3 && done3)) ov++;
    end
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_flags", {29'd0, id_ok, ts_ok, mm}, 32'd0);
    check("rst_cid", cid, 32'd0);
    check("rst_cts", cts, 32'd0);

    // Clean run, with a start pulse at cycle 3 that must be ignored.
    @(negedge clk);
    rst = 1'b0;
    measure(3, lat, lat3, a1, a13, both);
    check("lat_ign_start", 32'(lat), 32'(LAT));
    check("lat3_ign_start", 32'(lat3), 32'(LAT3));
    check("addr1_cycles", 32'(a1), 32'(A1));
    check("addr1_cycles_rl3", 32'(a13), 32'(A1_3));
    check("busy_done_overlap", 32'(both), 32'd0);
    check("good_flags", {29'd0, id_ok, ts_ok, mm}, 32'b110);
    check("good_cid", cid, EXP_ID);
    check("good_cts", cts, CTS_GOOD);
    check("good_busy", 32'(busy), 32'd0);
    check("rl3_flags", {29'd0, id_ok3, ts_ok3, mm3}, 32'b110);
    check("rl3_cid", cid3, EXP_ID);
    check("rl3_cts", cts3, CTS_GOOD);

    // Restart from DONE: results clear on the next edge, then the full sequence reruns.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart_done", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_flags", {29'd0, id_ok, ts_ok, mm}, 32'd0);
    check("restart_cid", cid, 32'd0);
    check("restart_cts", cts, 32'd0);
    measure(0, lat, lat3, a1, a13, both);
    check("restart_lat", 32'(lat), 32'(LAT));
    check("restart_lat3", 32'(lat3), 32'(LAT3));
    check("restart_flags2", {29'd0, id_ok, ts_ok, mm}, 32'b110);

    // One-bit ID error.
    id_val = 32'h0000_ABCE;
    do_reset();
    measure(0, lat, lat3, a1, a13, both);
    check("badid_lat", 32'(lat), 32'(LAT));
    check("badid_flags", {29'd0, id_ok, ts_ok, mm}, 32'b011);
    check("badid_cid", cid, 32'h0000_ABCE);
    check("badid_rl3_flags", {29'd0, id_ok3, ts_ok3, mm3}, 32'b011);

    // One-bit timestamp error.
    id_val = EXP_ID;
    ts_val = 32'h5989_F5E9;
    do_reset();
    measure(0, lat, lat3, a1, a13, both);
    check("badts_flags", {29'd0, id_ok, ts_ok, mm}, {29'd0, 1'b1, TS_OK_BADTS, ~TS_OK_BADTS});
    ts_val = EXP_TS;

    // Reset asserted at cycle 6, after the ID has been captured.
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    check("pre_abort_cid", cid, EXP_ID);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_cid", cid, 32'd0);
    check("abort_flags", {28'd0, addr, id_ok, ts_ok, mm}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    measure(0, lat, lat3, a1, a13, both);
    check("abort_lat", 32'(lat), 32'(LAT));
    check("abort_flags2", {29'd0, id_ok, ts_ok, mm}, 32'b110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
